// File: rtl/reg_dump_serializer.sv
// Walks the register file R0..R(NUM_REGS-1) on start and streams every byte MSB-first.
// 1 LOAD + DATA_W SHIFT cycles per register; ser_ready low freezes the SHIFT state.
module reg_dump_serializer #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              ser_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_first,
    output logic              ser_last,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  BIT_TOP  = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] reg_idx_q, reg_idx_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            reg_idx_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            reg_idx_q <= reg_idx_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        reg_idx_d = reg_idx_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        ser_first = 1'b0;
        ser_last  = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    reg_idx_d = '0;
                end
            end
            // Register is sampled here, so writes landing before this cycle are visible.
            S_LOAD: begin
                shreg_d   = rd_data;
                bit_cnt_d = BIT_TOP;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                ser_valid = 1'b1;
                ser_data  = shreg_q[DATA_W-1];
                ser_first = (reg_idx_q == '0) && (bit_cnt_q == BIT_TOP);
                ser_last  = (reg_idx_q == LAST_IDX) && (bit_cnt_q == '0);
                if (ser_ready) begin
                    if (bit_cnt_q != '0) begin
                        shreg_d   = shreg_q << 1;
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    end else if (reg_idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        reg_idx_d = reg_idx_q + ADDR_W'(1);
                        state_d   = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign rd_addr = reg_idx_q;

endmodule

// File: tb/tb_reg_dump_serializer.sv
// Directed bench for reg_dump_serializer: register file model plus per-run stream recorder.
module tb_reg_dump_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic       ser_data, ser_valid, ser_ready, ser_first, ser_last, busy, done;

    logic [7:0] regs [4];
    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    reg_dump_serializer #(.NUM_REGS(4), .DATA_W(8), .ADDR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .busy      (busy),
        .done      (done)
    );

    int tests = 0;
    int fails = 0;

    // Run configuration
    logic [127:0] start_mask;
    int stall_at, stall_len;
    int wr0_cyc, wr1_cyc;
    int wr0_idx, wr1_idx;
    logic [7:0] wr0_val, wr1_val;

    // Run results
    logic [63:0] frame;
    int nbits, valid_cnt, first_cnt, first_cyc, last_cnt, last_cyc;
    int done_cnt, done_cyc, busy_cnt, busy_first, busy_last, hold_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cfg();
        start_mask = '0;
        stall_at   = 1000;
        stall_len  = 0;
        wr0_cyc    = -1;
        wr1_cyc    = -1;
        wr0_idx    = 0;
        wr1_idx    = 0;
        wr0_val    = 8'h00;
        wr1_val    = 8'h00;
    endtask

    // Entered 1ns after a rising edge; cycle c runs until edge c.
    task automatic run(input int ncyc);
        frame = '0; nbits = 0; valid_cnt = 0; first_cnt = 0; first_cyc = 0;
        last_cnt = 0; last_cyc = 0; done_cnt = 0; done_cyc = 0;
        busy_cnt = 0; busy_first = 0; busy_last = 0; hold_cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            start     = start_mask[c];
            ser_ready = !(c >= stall_at && c < stall_at + stall_len);
            if (c == wr0_cyc) regs[wr0_idx] = wr0_val;
            if (c == wr1_cyc) regs[wr1_idx] = wr1_val;
            #1;
            if (c >= 1) begin
                if (ser_valid && ser_ready) begin
                    frame = {frame[62:0], ser_data};
                    nbits++;
                end
                if (ser_valid) valid_cnt++;
                if (ser_first) begin first_cnt++; first_cyc = c; end
                if (ser_last) begin last_cnt++; last_cyc = c; end
                if (done) begin done_cnt++; done_cyc = c; end
                if (busy) begin
                    busy_cnt++;
                    if (busy_first == 0) busy_first = c;
                    busy_last = c;
                end
                if (!ser_ready && ser_valid && ser_data && !ser_first && !ser_last) hold_cnt++;
            end
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        ser_ready = 1'b1;
    endtask

    initial begin
        regs[0] = 8'hA5; regs[1] = 8'h3C; regs[2] = 8'hFF; regs[3] = 8'h01;
        reset = 1'b1; start = 1'b0; ser_ready = 1'b1;
        clear_cfg();
        #12;
        chk("reset_outputs", 64'({rd_addr, ser_data, ser_valid, ser_first, ser_last, busy, done}), 64'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Plain dump, ready always high
        start_mask[0] = 1'b1;
        run(40);
        chk("basic_frame", frame, 64'hA53CFF01);
        chk("basic_nbits", nbits, 32);
        chk("basic_valid_cnt", valid_cnt, 32);
        chk("basic_first_cyc", first_cyc, 2);
        chk("basic_first_cnt", first_cnt, 1);
        chk("basic_last_cyc", last_cyc, 36);
        chk("basic_last_cnt", last_cnt, 1);
        chk("basic_done_cyc", done_cyc, 37);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_busy_cnt", busy_cnt, 37);
        chk("basic_busy_first", busy_first, 1);
        chk("basic_busy_last", busy_last, 37);

        // Ready low for 3 cycles after the 3rd bit of R1
        clear_cfg();
        start_mask[0] = 1'b1;
        stall_at = 14; stall_len = 3;
        run(44);
        chk("stall_frame", frame, 64'hA53CFF01);
        chk("stall_hold", hold_cnt, 3);
        chk("stall_valid_cnt", valid_cnt, 35);
        chk("stall_last_cyc", last_cyc, 39);
        chk("stall_done_cyc", done_cyc, 40);

        // Start while busy and in DONE is ignored
        clear_cfg();
        start_mask[0] = 1'b1; start_mask[5] = 1'b1; start_mask[20] = 1'b1; start_mask[37] = 1'b1;
        run(46);
        chk("restart_nbits", nbits, 32);
        chk("restart_frame", frame, 64'hA53CFF01);
        chk("restart_done_cnt", done_cnt, 1);
        chk("restart_busy_last", busy_last, 37);
        chk("restart_busy_cnt", busy_cnt, 37);

        // Non-atomic dump: R3 written before its LOAD, R0 after its LOAD
        clear_cfg();
        start_mask[0] = 1'b1;
        wr0_cyc = 4;  wr0_idx = 3; wr0_val = 8'h77;
        wr1_cyc = 12; wr1_idx = 0; wr1_val = 8'h00;
        run(40);
        chk("write_frame", frame, 64'hA53CFF77);
        regs[0] = 8'hA5; regs[3] = 8'h01;

        // Back-to-back dumps, second start in cycle 38
        clear_cfg();
        start_mask[0] = 1'b1; start_mask[38] = 1'b1;
        run(80);
        chk("b2b_frame", frame, 64'hA53CFF01A53CFF01);
        chk("b2b_nbits", nbits, 64);
        chk("b2b_first_cnt", first_cnt, 2);
        chk("b2b_second_first_cyc", first_cyc, 40);
        chk("b2b_done_cnt", done_cnt, 2);
        chk("b2b_second_done_cyc", done_cyc, 75);

        // Reset during the 5th bit of R1
        clear_cfg();
        start_mask[0] = 1'b1;
        run(15);
        chk("midreset_pre_bit", 64'({ser_valid, ser_data}), 64'h3);
        chk("midreset_partial_nbits", nbits, 12);
        chk("midreset_no_last", last_cnt, 0);
        reset = 1'b1;
        #1;
        chk("midreset_outputs", 64'({rd_addr, ser_data, ser_valid, ser_first, ser_last, busy, done}), 64'h0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        clear_cfg();
        start_mask[0] = 1'b1;
        run(40);
        chk("postreset_frame", frame, 64'hA53CFF01);
        chk("postreset_first_cyc", first_cyc, 2);
        chk("postreset_done_cyc", done_cyc, 37);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
